// File: rtl/memory_bus_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data has priority; fetch is guaranteed a grant after MAX_DATA_STREAK data grants.
module memory_bus_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instruction_request,
  input  logic [ADDR_WIDTH-1:0] instruction_address,
  output logic                  instruction_response,
  output logic [DATA_WIDTH-1:0] instruction_data,
  input  logic                  data_memory_read,
  input  logic                  data_memory_write,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  data_memory_response,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_response
);

  typedef enum logic [2:0] {
    IDLE,
    INSTR_WAIT,
    DATA_WAIT,
    INSTR_RESP,
    DATA_RESP
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t                state;
  state_t                state_next;
  logic [3:0]            streak;
  logic [3:0]            streak_next;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  data_req;
  logic                  fetch_starved;
  logic                  grant_data;
  logic                  grant_instr;

  always_comb begin
    state_next    = state;
    streak_next   = streak;
    data_req      = data_memory_read | data_memory_write;
    fetch_starved = instruction_request && (streak == STREAK_MAX);
    grant_data    = 1'b0;
    grant_instr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (data_req && !fetch_starved) begin
          grant_data = 1'b1;
          state_next = DATA_WAIT;
          if (!instruction_request)
            streak_next = 4'd0;
          else if (streak != 4'hF)
            streak_next = streak + 4'd1;
        end else if (instruction_request) begin
          grant_instr = 1'b1;
          state_next  = INSTR_WAIT;
          streak_next = 4'd0;
        end
      end
      DATA_WAIT: begin
        if (mem_response)
          state_next = DATA_RESP;
      end
      INSTR_WAIT: begin
        if (mem_response)
          state_next = INSTR_RESP;
      end
      INSTR_RESP: state_next = IDLE;
      DATA_RESP:  state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      streak <= 4'd0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
    end
  end

  // Responses are registered on the mem_response edge so they land in *_RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read             <= 1'b0;
      mem_write            <= 1'b0;
      mem_address          <= '0;
      mem_write_data       <= '0;
      fetch_addr           <= '0;
      instruction_data     <= '0;
      read_data            <= '0;
      instruction_response <= 1'b0;
      data_memory_response <= 1'b0;
    end else begin
      instruction_response <= 1'b0;
      data_memory_response <= 1'b0;
      if (grant_data) begin
        mem_address    <= data_address;
        mem_write_data <= write_data;
        mem_write      <= data_memory_write;
        mem_read       <= !data_memory_write;
      end
      if (grant_instr) begin
        mem_address <= instruction_address;
        fetch_addr  <= instruction_address;
        mem_read    <= 1'b1;
        mem_write   <= 1'b0;
      end
      if (state == DATA_WAIT && mem_response) begin
        mem_read             <= 1'b0;
        mem_write            <= 1'b0;
        data_memory_response <= 1'b1;
        if (mem_read)
          read_data <= mem_read_data;
      end
      // A PC change during the wait means the fetched word is stale.
      if (state == INSTR_WAIT && mem_response) begin
        mem_read <= 1'b0;
        if (instruction_address == fetch_addr) begin
          instruction_data     <= mem_read_data;
          instruction_response <= 1'b1;
        end
      end
    end
  end

endmodule
